key_schedule_engine: RTL and testbench

//  Sequential AES key expander; generates round keys one 32-bit word per cycle.
//  Key size is selected per key load at run time: 128, 192 or 256 bits.

---
 rtl/key_schedule_engine.sv | 276 +++++++++++++++++++++++++++
 tb/tb_key_schedule_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_engine.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_engine
// Brief    : Sequential AES key expander for 128/192/256-bit keys. Produces
//            one schedule word per cycle, stores up to 60 words and serves
//            one 128-bit round key per read, indexed by round number.
// Options  : KEY_SCHED_EQINV_EN adds the eqinv input; when set with a key,
//            reads of the inner round keys return InvMixColumns of each
//            column (equivalent inverse cipher). Storage is unaffected.
// Revision : 1.0 - initial release
// ============================================================================

// AES S-box: GF(2^8) inverse (as x^254) followed by the affine map.
module key_schedule_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // square-and-multiply chain: x^2 * x^4 * ... * x^128 = x^254 (0 maps to 0)
  always_comb begin
    w_sq  = din;
    w_inv = 8'h01;
    for (int n = 0; n < 7; n++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
    dout = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
         ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end
endmodule

module key_schedule_engine #(
  parameter int MAX_KEY_SIZE = 256,
  parameter int RD_LATENCY   = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:0]   key_mode,
  input  logic [255:0] key_in,
`ifdef KEY_SCHED_EQINV_EN
  input  logic         eqinv,
`endif
  output logic         key_err,
  output logic         keys_valid,
  output logic [3:0]   num_rounds,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_valid,
  output logic         rk_rd_err
);
  localparam int c_nr_max = (MAX_KEY_SIZE >= 256) ? 14 : (MAX_KEY_SIZE >= 192) ? 12 : 10;
  localparam int c_nwords = 4 * (c_nr_max + 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_load   = 2'd1;
  localparam logic [1:0] c_st_expand = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [255:0] r_key;
  logic [3:0]   r_nk;
  logic [3:0]   r_nr;
  logic [5:0]   r_i;
  logic [2:0]   r_wrap;
  logic [7:0]   r_rcon;
  logic         r_key_err;
  logic [31:0]  r_w [0:c_nwords-1];

  logic         w_accept;
  logic         w_mode_ok;
  logic [3:0]   w_nk_new;
  logic [3:0]   w_nr_new;
  logic         w_done;
  logic [5:0]   w_last;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_new;
  logic         w_rd_err;
  logic [5:0]   w_rd_base;
  logic [127:0] w_rd_raw;
  logic [127:0] w_rd_word;
  logic [127:0] w_rd_data;

`ifdef KEY_SCHED_EQINV_EN
  logic r_eqinv;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
  endfunction
`endif

  // decode the offered key mode; sizes above MAX_KEY_SIZE are rejected like mode 3
  always_comb begin
    w_mode_ok = 1'b0;
    w_nk_new  = 4'd4;
    w_nr_new  = 4'd10;
    case (key_mode)
      2'd0: w_mode_ok = 1'b1;
      2'd1: begin w_mode_ok = (MAX_KEY_SIZE >= 192); w_nk_new = 4'd6; w_nr_new = 4'd12; end
      2'd2: begin w_mode_ok = (MAX_KEY_SIZE >= 256); w_nk_new = 4'd8; w_nr_new = 4'd14; end
      default: w_mode_ok = 1'b0;
    endcase
  end

  assign w_accept = key_valid & key_ready;
  assign w_last   = {r_nr, 2'b11};

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: a new key is only taken in IDLE or DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: if (w_accept) w_state_nxt = w_mode_ok ? c_st_load : c_st_idle;
      c_st_load:            w_state_nxt = c_st_expand;
      c_st_expand:          if (r_i == w_last) w_state_nxt = c_st_done;
      default:              w_state_nxt = c_st_idle;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_done     = (r_state == c_st_done);
    key_ready  = (r_state == c_st_idle) || (r_state == c_st_done);
    keys_valid = w_done;
    num_rounds = w_done ? r_nr : 4'd0;
    key_err    = r_key_err;
  end

  // expansion control: word index, position within Nk and round constant
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_key_err <= 1'b0;
      r_nk      <= 4'd4;
      r_nr      <= 4'd10;
      r_i       <= 6'd0;
      r_wrap    <= 3'd0;
      r_rcon    <= 8'h01;
    end else begin
      r_key_err <= w_accept & ~w_mode_ok;
      if (w_accept) begin
        r_nk <= w_nk_new;
        r_nr <= w_nr_new;
      end
      if (r_state == c_st_load) begin
        r_i    <= {2'b00, r_nk};
        r_wrap <= 3'd0;
        r_rcon <= 8'h01;
      end else if (r_state == c_st_expand) begin
        r_i    <= r_i + 6'd1;
        r_wrap <= ({1'b0, r_wrap} == (r_nk - 4'd1)) ? 3'd0 : r_wrap + 3'd1;
        if (r_wrap == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  // next schedule word from w[i-1] and w[i-Nk]
  always_comb begin
    w_prev   = r_w[r_i - 6'd1];
    w_back   = r_w[r_i - {2'b00, r_nk}];
    w_sub_in = (r_wrap == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    if (r_wrap == 3'd0)
      w_new = w_back ^ w_sub_out ^ {r_rcon, 24'h000000};
    else if ((r_nk == 4'd8) && (r_wrap == 3'd4))
      w_new = w_back ^ w_sub_out;
    else
      w_new = w_back ^ w_prev;
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_sbox
      key_schedule_sbox u_sbox (
        .din  (w_sub_in[8*g +: 8]),
        .dout (w_sub_out[8*g +: 8])
      );
    end
  endgenerate

  // key capture and word storage; storage is deliberately left uninitialised
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_key <= key_in;
`ifdef KEY_SCHED_EQINV_EN
      r_eqinv <= eqinv;
`endif
    end
    if (r_state == c_st_load) begin
      for (int k = 0; k < 8; k++)
        if (4'(k) < r_nk) r_w[6'(k)] <= r_key[255-32*k -: 32];
    end else if (r_state == c_st_expand) begin
      r_w[r_i] <= w_new;
    end
  end

  // read path: bad index or no schedule returns zero data and an error
  always_comb begin
    w_rd_err  = ~w_done | (rk_rd_idx > r_nr);
    w_rd_base = w_rd_err ? 6'd0 : {rk_rd_idx, 2'b00};
    w_rd_raw  = {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                 r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
    w_rd_word = w_rd_raw;
`ifdef KEY_SCHED_EQINV_EN
    if (r_eqinv && (rk_rd_idx != 4'd0) && (rk_rd_idx != r_nr))
      w_rd_word = {inv_mix_col(w_rd_raw[127:96]), inv_mix_col(w_rd_raw[95:64]),
                   inv_mix_col(w_rd_raw[63:32]),  inv_mix_col(w_rd_raw[31:0])};
`endif
    w_rd_data = w_rd_err ? 128'd0 : w_rd_word;
  end

  generate
    if (RD_LATENCY == 0) begin : g_rd_comb
      // combinational read response
      always_comb begin
        rk_rd_valid = rk_rd_en;
        rk_rd_err   = rk_rd_en & w_rd_err;
        rk_rd_data  = rk_rd_en ? w_rd_data : 128'd0;
      end
    end else begin : g_rd_reg
      // registered read response, one request per cycle
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          rk_rd_valid <= 1'b0;
          rk_rd_err   <= 1'b0;
          rk_rd_data  <= 128'd0;
        end else begin
          rk_rd_valid <= rk_rd_en;
          rk_rd_err   <= rk_rd_en & w_rd_err;
          if (rk_rd_en) rk_rd_data <= w_rd_data;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule_engine
// Brief    : Self-checking bench for key_schedule_engine (default build).
//            Round keys are compared against a FIPS-197 style expansion
//            model built from a generator-derived S-box table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_schedule_engine;
  logic         clock = 1'b0;
  logic         reset_n;
  logic         key_valid;
  logic         key_ready;
  logic [1:0]   key_mode;
  logic [255:0] key_in;
  logic         key_err;
  logic         keys_valid;
  logic [3:0]   num_rounds;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_rd_valid;
  logic         rk_rd_err;
`ifdef KEY_SCHED_EQINV_EN
  logic         eqinv = 1'b0;
`endif

  int n_vec;
  int n_err;

  logic [7:0]  sb [0:255];
  logic [7:0]  rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] mw [0:63];
  int          m_nr;

  localparam logic [255:0] c_k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] c_k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] c_k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clock = ~clock;

  key_schedule_engine dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_mode    (key_mode),
    .key_in      (key_in),
`ifdef KEY_SCHED_EQINV_EN
    .eqinv       (eqinv),
`endif
    .key_err     (key_err),
    .keys_valid  (keys_valid),
    .num_rounds  (num_rounds),
    .rk_rd_en    (rk_rd_en),
    .rk_rd_idx   (rk_rd_idx),
    .rk_rd_data  (rk_rd_data),
    .rk_rd_valid (rk_rd_valid),
    .rk_rd_err   (rk_rd_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // S-box from the multiplicative generator 3 and its inverse walk
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    m_nr = nk + 6;
    for (int i = 0; i < 64; i++) mw[i] = 32'h0;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % 8 == 4)
        t = sub_word(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // offer a key, optionally keep key_valid high for 'hold' cycles with junk,
  // optionally read r10 in the accept cycle, then wait for keys_valid
  task automatic load_key(input logic [1:0] mode, input logic [255:0] key, input int hold,
                          input bit rd_same, input logic [127:0] old_r10);
    int n;
    int lat;
    lat = (mode == 2'd0) ? 42 : (mode == 2'd1) ? 48 : 54;
    key_valid = 1'b1;
    key_mode  = mode;
    key_in    = key;
    if (rd_same) begin
      rk_rd_en  = 1'b1;
      rk_rd_idx = 4'd10;
    end
    step();
    n = 1;
    if (rd_same) begin
      rk_rd_en = 1'b0;
      check("accept_rd_valid", rk_rd_valid, 1);
      check("accept_rd_err", rk_rd_err, 0);
      check("accept_rd_old_r10", rk_rd_data, old_r10);
      check("accept_kv_drop", keys_valid, 0);
    end
    if (hold == 0) key_valid = 1'b0;
    else begin
      key_in   = rand256();
      key_mode = 2'($urandom_range(0, 2));
    end
    while (!keys_valid && n < 200) begin
      if (n == hold) key_valid = 1'b0;
      if (n == 5) check("busy_key_ready", key_ready, 0);
      step();
      n++;
    end
    key_valid = 1'b0;
    check("latency", n, lat);
    model_expand(key, 4 + 2 * int'(mode));
    check("num_rounds", num_rounds, m_nr);
  endtask

  task automatic read_rk(input int r, output logic [127:0] d, output logic e);
    rk_rd_en  = 1'b1;
    rk_rd_idx = 4'(r);
    step();
    rk_rd_en = 1'b0;
    check("rd_valid", rk_rd_valid, 1);
    d = rk_rd_data;
    e = rk_rd_err;
  endtask

  // back-to-back reads of every index against the model
  task automatic read_burst(input bit kv);
    bit e;
    for (int r = 0; r < 16; r++) begin
      rk_rd_en  = 1'b1;
      rk_rd_idx = 4'(r);
      step();
      e = !kv || (r > m_nr);
      check("burst_valid", rk_rd_valid, 1);
      check("burst_err", rk_rd_err, e);
      if (e) check("burst_data_zero", rk_rd_data, 0);
      else   check($sformatf("burst_r%0d", r), rk_rd_data, model_rk(r));
    end
    rk_rd_en = 1'b0;
    step();
    check("burst_valid_drop", rk_rd_valid, 0);
  endtask

  initial begin
    logic [127:0] d;
    logic         e;
    logic [1:0]   m;
    n_vec = 0;
    n_err = 0;
    build_sbox();
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_mode  = 2'd0;
    key_in    = '0;
    rk_rd_en  = 1'b0;
    rk_rd_idx = 4'd0;
    repeat (3) step();
    reset_n = 1'b1;

    check("rst_key_ready", key_ready, 1);
    check("rst_keys_valid", keys_valid, 0);
    check("rst_num_rounds", num_rounds, 0);
    check("rst_key_err", key_err, 0);
    check("rst_rd_valid", rk_rd_valid, 0);
    check("rst_rd_err", rk_rd_err, 0);
    check("rst_rd_data", rk_rd_data, 0);
    read_rk(0, d, e);
    check("rst_read_err", e, 1);

    // AES-128 known answer
    load_key(2'd0, c_k128, 0, 1'b0, '0);
    read_rk(1, d, e);
    check("k128_r1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10, d, e);
    check("k128_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_burst(1'b1);

    // AES-192 known answer
    load_key(2'd1, c_k192, 0, 1'b0, '0);
    check("k192_nr", num_rounds, 12);
    read_rk(12, d, e);
    check("k192_r12", d, 128'he98ba06f448c773c8ecc720401002202);
    read_burst(1'b1);

    // AES-256 known answer and out-of-range index
    load_key(2'd2, c_k256, 0, 1'b0, '0);
    read_rk(14, d, e);
    check("k256_r14", d, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk(15, d, e);
    check("k256_r15_err", e, 1);
    check("k256_r15_data", d, 0);
    read_burst(1'b1);

    // random keys, random sizes, random key_valid hold during expansion
    for (int t = 0; t < 6; t++) begin
      m = 2'($urandom_range(0, 2));
      load_key(m, rand256(), (t % 2 == 0) ? 0 : int'($urandom_range(2, 35)), 1'b0, '0);
      read_burst(1'b1);
    end

    // illegal mode
    key_valid = 1'b1;
    key_mode  = 2'd3;
    key_in    = rand256();
    step();
    key_valid = 1'b0;
    check("illegal_key_err", key_err, 1);
    check("illegal_keys_valid", keys_valid, 0);
    check("illegal_key_ready", key_ready, 1);
    step();
    check("illegal_key_err_pulse", key_err, 0);
    check("illegal_keys_valid_stay", keys_valid, 0);
    read_rk(0, d, e);
    check("illegal_read_err", e, 1);

    // reset during an AES-256 expansion
    key_valid = 1'b1;
    key_mode  = 2'd2;
    key_in    = c_k256;
    step();
    key_valid = 1'b0;
    repeat (19) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_keys_valid", keys_valid, 0);
    check("midrst_key_ready", key_ready, 1);
    check("midrst_num_rounds", num_rounds, 0);
    repeat (60) step();
    check("midrst_keys_valid_late", keys_valid, 0);
    read_rk(0, d, e);
    check("midrst_read_err", e, 1);
    check("midrst_read_data", d, 0);

    // read served from the old schedule in the accept cycle, key_valid held
    load_key(2'd0, c_k128, 0, 1'b0, '0);
    load_key(2'd2, c_k256, 30, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_burst(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
